// File: rtl/psram_sched_if.sv
// Controller-side command/data bundle between psram_sched (master) and the PSRAM controller (slave).
interface psram_sched_if;
  logic        start;
  logic [7:0]  cmd;
  logic        cmd_only;
  logic [1:0]  cmd_width;
  logic [23:0] addr;
  logic [1:0]  addr_width;
  logic [3:0]  wait_cyc;
  logic        data_dir;
  logic [15:0] data_len;
  logic [1:0]  data_width;
  logic        done;
  logic        tx_vld;
  logic [31:0] tx_data;
  logic        tx_free;
  logic        rx_rdy;
  logic        rx_vld;
  logic [31:0] rx_data;

  modport master (
    output start, cmd, cmd_only, cmd_width, addr, addr_width, wait_cyc,
           data_dir, data_len, data_width, tx_vld, tx_data, rx_rdy,
    input  done, tx_free, rx_vld, rx_data
  );
  modport slave (
    input  start, cmd, cmd_only, cmd_width, addr, addr_width, wait_cyc,
           data_dir, data_len, data_width, tx_vld, tx_data, rx_rdy,
    output done, tx_free, rx_vld, rx_data
  );
endinterface

// File: rtl/psram_sched.sv
// Two-requester round-robin scheduler in front of a quad PSRAM controller.
// Define PSRAM_SCHED_INIT_SEQ_EN to issue the 66/99/35 reset/quad-enable sequence after reset.
module psram_sched #(
    parameter int unsigned WAIT_CYC = 6,
    parameter logic [7:0]  RD_CMD   = 8'hEB,
    parameter logic [7:0]  WR_CMD   = 8'h38
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_vld,
    input  logic        req0_wr,
    input  logic [23:0] req0_addr,
    input  logic [15:0] req0_len,
    output logic        req0_gnt,
    output logic        req0_done,
    input  logic        req1_vld,
    input  logic        req1_wr,
    input  logic [23:0] req1_addr,
    input  logic [15:0] req1_len,
    output logic        req1_gnt,
    output logic        req1_done,
    input  logic        req0_tx_vld,
    input  logic [31:0] req0_tx_data,
    output logic        req0_tx_free,
    input  logic        req0_rx_rdy,
    output logic        req0_rx_vld,
    output logic [31:0] req0_rx_data,
    input  logic        req1_tx_vld,
    input  logic [31:0] req1_tx_data,
    output logic        req1_tx_free,
    input  logic        req1_rx_rdy,
    output logic        req1_rx_vld,
    output logic [31:0] req1_rx_data,
    output logic        busy,
    psram_sched_if.master ctrl
);

`ifdef PSRAM_SCHED_INIT_SEQ_EN
    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT_DONE, COMPLETE} state_e;
    localparam state_e RST_STATE = INIT;
    logic [1:0] init_idx_q, init_idx_d;
    logic       init_wait_q, init_wait_d;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE} state_e;
    localparam state_e RST_STATE = IDLE;
`endif

    state_e      state_q, state_d;
    logic        owner_q, owner_d, pri_q, pri_d, zlen_q, zlen_d, start_q, start_d;
    logic [1:0]  gnt_q, gnt_d, cmd_width_q, cmd_width_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        cmd_only_q, cmd_only_d, dir_q, dir_d;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] dlen_q, dlen_d;
    logic        sel, xfer;

    // Both pending: the one not served last wins; otherwise whoever is asking.
    assign sel = (req0_vld && req1_vld) ? pri_q : req1_vld;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        pri_d       = pri_q;
        zlen_d      = zlen_q;
        gnt_d       = 2'b00;
        start_d     = 1'b0;
        cmd_d       = cmd_q;
        cmd_only_d  = cmd_only_q;
        cmd_width_d = cmd_width_q;
        addr_d      = addr_q;
        wait_d      = wait_q;
        dir_d       = dir_q;
        dlen_d      = dlen_q;
`ifdef PSRAM_SCHED_INIT_SEQ_EN
        init_idx_d  = init_idx_q;
        init_wait_d = init_wait_q;
`endif
        case (state_q)
`ifdef PSRAM_SCHED_INIT_SEQ_EN
            INIT: begin
                if (!init_wait_q) begin
                    start_d     = 1'b1;
                    init_wait_d = 1'b1;
                    cmd_d       = (init_idx_q == 2'd0) ? 8'h66 :
                                  (init_idx_q == 2'd1) ? 8'h99 : 8'h35;
                    cmd_only_d  = 1'b1;
                    cmd_width_d = 2'b00;
                    wait_d      = 4'd0;
                    dir_d       = 1'b0;
                    dlen_d      = 16'd0;
                end else if (ctrl.done) begin
                    init_wait_d = 1'b0;
                    init_idx_d  = init_idx_q + 2'd1;
                    if (init_idx_q == 2'd2) state_d = IDLE;
                end
            end
`endif
            IDLE: begin
                if (req0_vld || req1_vld) begin
                    owner_d     = sel;
                    gnt_d[sel]  = 1'b1;
                    dir_d       = sel ? req1_wr : req0_wr;
                    addr_d      = sel ? req1_addr : req0_addr;
                    dlen_d      = (sel ? req1_len : req0_len) - 16'd1;
                    zlen_d      = (sel ? req1_len : req0_len) == 16'd0;
                    cmd_d       = dir_d ? WR_CMD : RD_CMD;
                    wait_d      = dir_d ? 4'd0 : 4'(WAIT_CYC);
                    cmd_only_d  = 1'b0;
                    cmd_width_d = 2'b10;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (zlen_q) state_d = COMPLETE;
                else begin
                    start_d = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: if (ctrl.done) state_d = COMPLETE;
            COMPLETE: begin
                pri_d   = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            owner_q     <= 1'b0;
            pri_q       <= 1'b0;
            zlen_q      <= 1'b0;
            gnt_q       <= 2'b00;
            start_q     <= 1'b0;
            cmd_q       <= 8'h00;
            cmd_only_q  <= 1'b0;
            cmd_width_q <= 2'b00;
            addr_q      <= 24'h0;
            wait_q      <= 4'd0;
            dir_q       <= 1'b0;
            dlen_q      <= 16'd0;
`ifdef PSRAM_SCHED_INIT_SEQ_EN
            init_idx_q  <= 2'd0;
            init_wait_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            pri_q       <= pri_d;
            zlen_q      <= zlen_d;
            gnt_q       <= gnt_d;
            start_q     <= start_d;
            cmd_q       <= cmd_d;
            cmd_only_q  <= cmd_only_d;
            cmd_width_q <= cmd_width_d;
            addr_q      <= addr_d;
            wait_q      <= wait_d;
            dir_q       <= dir_d;
            dlen_q      <= dlen_d;
`ifdef PSRAM_SCHED_INIT_SEQ_EN
            init_idx_q  <= init_idx_d;
            init_wait_q <= init_wait_d;
`endif
        end
    end

    assign req0_gnt  = gnt_q[0];
    assign req1_gnt  = gnt_q[1];
    assign req0_done = (state_q == COMPLETE) && !owner_q;
    assign req1_done = (state_q == COMPLETE) && owner_q;
    assign busy      = (state_q != IDLE);

    assign ctrl.start      = start_q;
    assign ctrl.cmd        = cmd_q;
    assign ctrl.cmd_only   = cmd_only_q;
    assign ctrl.cmd_width  = cmd_width_q;
    assign ctrl.addr       = addr_q;
    assign ctrl.addr_width = 2'b10;
    assign ctrl.wait_cyc   = wait_q;
    assign ctrl.data_dir   = dir_q;
    assign ctrl.data_len   = dlen_q;
    assign ctrl.data_width = 2'b10;

    // Data path belongs to the owner only while its transfer is in flight.
    assign xfer         = (state_q == ISSUE) || (state_q == WAIT_DONE);
    assign ctrl.tx_vld  = xfer && (owner_q ? req1_tx_vld : req0_tx_vld);
    assign ctrl.tx_data = owner_q ? req1_tx_data : req0_tx_data;
    assign ctrl.rx_rdy  = xfer && (owner_q ? req1_rx_rdy : req0_rx_rdy);
    assign req0_tx_free = xfer && !owner_q && ctrl.tx_free;
    assign req1_tx_free = xfer && owner_q && ctrl.tx_free;
    assign req0_rx_vld  = xfer && !owner_q && ctrl.rx_vld;
    assign req1_rx_vld  = xfer && owner_q && ctrl.rx_vld;
    assign req0_rx_data = ctrl.rx_data;
    assign req1_rx_data = ctrl.rx_data;

endmodule

// File: tb/tb_psram_sched.sv
// Directed bench for psram_sched: arbitration, field encoding, data mux, zero length, reset abort.
module tb_psram_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_vld, req0_wr, req1_vld, req1_wr;
  logic [23:0] req0_addr, req1_addr;
  logic [15:0] req0_len, req1_len;
  logic        req0_gnt, req0_done, req1_gnt, req1_done;
  logic        req0_tx_vld, req0_tx_free, req0_rx_rdy, req0_rx_vld;
  logic        req1_tx_vld, req1_tx_free, req1_rx_rdy, req1_rx_vld;
  logic [31:0] req0_tx_data, req0_rx_data, req1_tx_data, req1_rx_data;
  logic        busy;
  int          errors = 0;
  int          checks = 0;

`ifdef PSRAM_SCHED_INIT_SEQ_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  psram_sched_if ctrl ();

  psram_sched dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_len(req0_len),
    .req0_gnt(req0_gnt), .req0_done(req0_done),
    .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_len(req1_len),
    .req1_gnt(req1_gnt), .req1_done(req1_done),
    .req0_tx_vld(req0_tx_vld), .req0_tx_data(req0_tx_data), .req0_tx_free(req0_tx_free),
    .req0_rx_rdy(req0_rx_rdy), .req0_rx_vld(req0_rx_vld), .req0_rx_data(req0_rx_data),
    .req1_tx_vld(req1_tx_vld), .req1_tx_data(req1_tx_data), .req1_tx_free(req1_tx_free),
    .req1_rx_rdy(req1_rx_rdy), .req1_rx_vld(req1_rx_vld), .req1_rx_data(req1_rx_data),
    .busy(busy), .ctrl(ctrl.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller side of the power-up sequence; nothing to do in the default build.
  task automatic do_init();
    logic [7:0] exp_cmd [3];
    int n;
    exp_cmd[0] = 8'h66; exp_cmd[1] = 8'h99; exp_cmd[2] = 8'h35;
    if (INIT_EN) begin
      for (int k = 0; k < 3; k++) begin
        n = 0;
        while (ctrl.start !== 1'b1 && n < 20) begin tick(); n++; end
        chk("init_start", 32'(ctrl.start), 32'h1);
        chk("init_cmd", 32'(ctrl.cmd), 32'(exp_cmd[k]));
        chk("init_cmd_only", 32'(ctrl.cmd_only), 32'h1);
        chk("init_cmd_width", 32'(ctrl.cmd_width), 32'h0);
        chk("init_busy", 32'(busy), 32'h1);
        ctrl.done = 1'b1; tick(); ctrl.done = 1'b0;
      end
      chk("init_end_idle", 32'(busy), 32'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick();
    chk("rst_busy", 32'(busy), 32'(INIT_EN));
    chk("rst_start", 32'(ctrl.start), 32'h0);
    chk("rst_gnt", 32'({req1_gnt, req0_gnt}), 32'h0);
    chk("rst_done", 32'({req1_done, req0_done}), 32'h0);
    chk("rst_cmd", 32'(ctrl.cmd), 32'h0);
    chk("rst_addr", 32'(ctrl.addr), 32'h0);
    chk("rst_dlen", 32'(ctrl.data_len), 32'h0);
    rst = 1'b0; tick();
    do_init();
  endtask

  // Called right after the grant edge: start, one wait cycle, done, back to IDLE.
  task automatic finish_xfer(input logic who);
    tick();
    chk("fx_start", 32'(ctrl.start), 32'h1);
    tick();
    ctrl.done = 1'b1; tick(); ctrl.done = 1'b0;
    chk("fx_done", 32'({req1_done, req0_done}), who ? 32'h2 : 32'h1);
    tick();
    chk("fx_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    {req0_vld, req0_wr, req1_vld, req1_wr} = '0;
    req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
    {req0_tx_vld, req0_rx_rdy, req1_tx_vld, req1_rx_rdy} = '0;
    req0_tx_data = '0; req1_tx_data = '0;
    ctrl.done = 1'b0; ctrl.tx_free = 1'b0; ctrl.rx_vld = 1'b0; ctrl.rx_data = '0;

    // Round-robin: simultaneous after reset -> req0, req1 waits, then alternation
    do_reset();
    req0_vld = 1'b1; req0_addr = 24'h000010; req0_len = 16'd4;
    req1_vld = 1'b1; req1_addr = 24'h000020; req1_len = 16'd4;
    tick();
    chk("rr_gnt_first", 32'({req1_gnt, req0_gnt}), 32'h1);
    req0_vld = 1'b0;
    tick();
    chk("rr_start0", 32'(ctrl.start), 32'h1);
    chk("rr_addr0", 32'(ctrl.addr), 32'h10);
    tick();
    chk("rr_pending1", 32'(req1_gnt), 32'h0);
    ctrl.done = 1'b1; tick(); ctrl.done = 1'b0;
    chk("rr_done0", 32'({req1_done, req0_done}), 32'h1);
    chk("rr_no_gnt1_yet", 32'(req1_gnt), 32'h0);
    tick(); tick();
    chk("rr_gnt_second", 32'({req1_gnt, req0_gnt}), 32'h2);
    req1_vld = 1'b0;
    finish_xfer(1'b1);
    req0_vld = 1'b1; req1_vld = 1'b1;
    tick();
    chk("rr_gnt_third", 32'({req1_gnt, req0_gnt}), 32'h1);
    req0_vld = 1'b0; req1_vld = 1'b0;
    finish_xfer(1'b0);

    // Read len 8 from req0: timing and field encoding
    req0_vld = 1'b1; req0_wr = 1'b0; req0_addr = 24'h000100; req0_len = 16'd8;
    tick();
    chk("rd_gnt", 32'(req0_gnt), 32'h1);
    chk("rd_no_early_start", 32'(ctrl.start), 32'h0);
    chk("rd_busy", 32'(busy), 32'h1);
    req0_vld = 1'b0;
    tick();
    chk("rd_start", 32'(ctrl.start), 32'h1);
    chk("rd_cmd", 32'(ctrl.cmd), 32'hEB);
    chk("rd_wait", 32'(ctrl.wait_cyc), 32'h6);
    chk("rd_dlen", 32'(ctrl.data_len), 32'h7);
    chk("rd_dir", 32'(ctrl.data_dir), 32'h0);
    chk("rd_addr", 32'(ctrl.addr), 32'h100);
    chk("rd_widths", 32'({ctrl.cmd_width, ctrl.addr_width, ctrl.data_width}), 32'h2A);
    chk("rd_cmd_only", 32'(ctrl.cmd_only), 32'h0);
    tick();
    chk("rd_start_1cyc", 32'(ctrl.start), 32'h0);
    chk("rd_cmd_held", 32'(ctrl.cmd), 32'hEB);
    ctrl.done = 1'b1; tick(); ctrl.done = 1'b0;
    chk("rd_done0", 32'(req0_done), 32'h1);
    tick();
    chk("rd_done_1cyc", 32'(req0_done), 32'h0);
    chk("rd_idle", 32'(busy), 32'h0);

    // Write len 4 from req1 with data routing
    req1_vld = 1'b1; req1_wr = 1'b1; req1_addr = 24'h00ABCD; req1_len = 16'd4;
    tick();
    chk("wr_gnt", 32'({req1_gnt, req0_gnt}), 32'h2);
    req1_vld = 1'b0;
    tick();
    chk("wr_cmd", 32'(ctrl.cmd), 32'h38);
    chk("wr_wait", 32'(ctrl.wait_cyc), 32'h0);
    chk("wr_dir", 32'(ctrl.data_dir), 32'h1);
    chk("wr_dlen", 32'(ctrl.data_len), 32'h3);
    req1_tx_vld = 1'b1; req1_tx_data = 32'hDEADBEEF; req0_tx_vld = 1'b1; req0_tx_data = 32'h12345678;
    ctrl.tx_free = 1'b1; ctrl.rx_vld = 1'b1; ctrl.rx_data = 32'hCAFEF00D;
    #1;
    chk("wr_tx_vld", 32'(ctrl.tx_vld), 32'h1);
    chk("wr_tx_data", ctrl.tx_data, 32'hDEADBEEF);
    chk("wr_tx_free1", 32'(req1_tx_free), 32'h1);
    chk("wr_tx_free0", 32'(req0_tx_free), 32'h0);
    chk("wr_rx_vld0", 32'(req0_rx_vld), 32'h0);
    chk("wr_rx_vld1", 32'(req1_rx_vld), 32'h1);
    req1_tx_vld = 1'b0;
    tick();
    ctrl.done = 1'b1; tick(); ctrl.done = 1'b0;
    chk("wr_done1", 32'({req1_done, req0_done}), 32'h2);
    tick();
    chk("idle_tx_vld", 32'(ctrl.tx_vld), 32'h0);
    chk("idle_tx_free0", 32'(req0_tx_free), 32'h0);
    req0_tx_vld = 1'b0; ctrl.tx_free = 1'b0; ctrl.rx_vld = 1'b0;

    // Zero length: grant then done, no start
    req0_vld = 1'b1; req0_wr = 1'b0; req0_addr = 24'h000200; req0_len = 16'd0;
    tick();
    chk("z_gnt", 32'(req0_gnt), 32'h1);
    chk("z_no_done_yet", 32'(req0_done), 32'h0);
    req0_vld = 1'b0;
    tick();
    chk("z_done", 32'(req0_done), 32'h1);
    chk("z_no_start", 32'(ctrl.start), 32'h0);
    tick();
    chk("z_no_start2", 32'(ctrl.start), 32'h0);
    chk("z_idle", 32'(busy), 32'h0);

    // Reset in WAIT_DONE abandons the transfer
    req0_vld = 1'b1; req0_len = 16'd8; req0_addr = 24'h000300;
    tick();
    req0_vld = 1'b0;
    tick(); tick();
    ctrl.done = 1'b0; rst = 1'b1;
    tick();
    chk("ra_no_done", 32'(req0_done), 32'h0);
    chk("ra_busy", 32'(busy), 32'(INIT_EN));
    chk("ra_no_start", 32'(ctrl.start), 32'h0);
    rst = 1'b0;
    tick();
    chk("ra_no_start2", 32'(ctrl.start), 32'h0);
    do_init();
    req1_vld = 1'b1; req1_wr = 1'b0; req1_addr = 24'h000400; req1_len = 16'd2;
    tick();
    chk("ra_gnt1", 32'({req1_gnt, req0_gnt}), 32'h2);
    req1_vld = 1'b0;
    tick();
    chk("ra_start", 32'(ctrl.start), 32'h1);
    chk("ra_dlen", 32'(ctrl.data_len), 32'h1);
    chk("ra_addr", 32'(ctrl.addr), 32'h400);
    tick();
    ctrl.done = 1'b1; tick(); ctrl.done = 1'b0;
    chk("ra_done1", 32'({req1_done, req0_done}), 32'h2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
